// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID.
// Halts with a sticky fault on a misaligned redirect target.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  if_id_t      id_q;
  if_id_t      id_d;
  logic        fault_q;
  logic        fault_d;
  logic [31:0] fault_pc_q;
  logic [31:0] fault_pc_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  logic misaligned;
  logic redir_ok;
  logic redir_bad;
  logic hold;
  logic advance;

  assign misaligned = |redirect_pc[1:0];
  assign redir_ok   = redirect_valid && !misaligned;
  assign redir_bad  = redirect_valid && misaligned;
  assign hold       = !redirect_valid && stall_if;
  assign advance    = !redirect_valid && !stall_if;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_d       = id_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q;
    if (state_q == HALT) begin
      id_d.instr = NOP_INSTR;
      id_d.valid = 1'b0;
    end else begin
      unique case (1'b1)
        redir_ok: begin
          pc_d       = redirect_pc;
          id_d.instr = NOP_INSTR;
          id_d.valid = 1'b0;
        end
        redir_bad: begin
          fault_d    = 1'b1;
          fault_pc_d = redirect_pc;
          id_d.instr = NOP_INSTR;
          id_d.valid = 1'b0;
          state_d    = HALT;
        end
        hold: begin
        end
        advance: begin
          pc_d       = pc_q + 32'd4;
          id_d.pc    = pc_q;
          id_d.pc4   = pc_q + 32'd4;
          id_d.instr = imem_rdata;
          id_d.valid = 1'b1;
          cnt_d      = cnt_q + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_q.pc    <= 32'd0;
      id_q.pc4   <= 32'd0;
      id_q.instr <= NOP_INSTR;
      id_q.valid <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_q       <= id_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_pc     = id_q.pc;
  assign id_pc4    = id_q.pc4;
  assign id_instr  = id_q.instr;
  assign id_valid  = id_q.valid;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the model2 forwarding pipeline; sits directly upstream of the instruction memory.
- Owns the PC and drives the imem address. Captures the combinational imem read data into the IF/ID pipeline register.
- Takes stall from the hazard unit and redirects (taken branch, jal, jalr) from EX.
- Raises a sticky fault and stops fetching on a misaligned redirect target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble injected into IF/ID (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall_if  input  1  hazard unit: hold PC and IF/ID this cycle.
redirect_valid  input  1  EX: control transfer resolved taken this cycle.
redirect_pc  input  32  EX: target address for redirect.
imem_addr  output  32  byte address to imem (combinational = pc_q).
imem_rdata  input  32  instruction word from imem (combinational read of imem_addr).
id_pc  output  32  IF/ID: PC of held instruction.
id_pc4  output  32  IF/ID: id_pc + 4.
id_instr  output  32  IF/ID: instruction word.
id_valid  output  1  IF/ID: 1 = real instruction, 0 = bubble.
fault  output  1  sticky: misaligned redirect target seen.
fault_pc  output  32  offending redirect_pc.
fetch_cnt  output  32  count of instructions accepted into IF/ID.

Behaviour:
- State machine: RUN, HALT.
- Reset (rst=1 at edge), regardless of any other input:
  - state=RUN, pc_q=RESET_PC.
  - id_pc=0, id_pc4=0, id_instr=NOP_INSTR, id_valid=0.
  - fault=0, fault_pc=0, fetch_cnt=0.
- imem_addr = pc_q at all times. There is no extra read latency; imem_rdata belongs to pc_q in the same cycle.
- RUN, redirect_valid=1, redirect_pc[1:0]==0:
  - pc_q <= redirect_pc.
  - IF/ID flushed: id_instr=NOP_INSTR, id_valid=0, id_pc/id_pc4 unchanged.
  - Redirect overrides stall_if.
- RUN, redirect_valid=1, redirect_pc[1:0]!=0:
  - fault <= 1, fault_pc <= redirect_pc.
  - IF/ID flushed; pc_q holds; next state HALT.
- RUN, no redirect, stall_if=1: pc_q and all IF/ID fields hold; fetch_cnt holds.
- RUN, no redirect, stall_if=0:
  - pc_q <= pc_q + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - id_pc <= pc_q, id_pc4 <= pc_q + 4, id_instr <= imem_rdata, id_valid <= 1.
  - fetch_cnt <= fetch_cnt + 1, wrapping modulo 2^32.
- HALT:
  - pc_q holds; each cycle IF/ID loads the bubble (NOP_INSTR, valid=0).
  - Redirect and stall are ignored.
  - fault and fault_pc hold; fetch_cnt holds.
  - Leave HALT only via rst.
- Flushes (redirect, fault, HALT) never increment fetch_cnt.
- id_pc4 is always computed from the same PC stored in id_pc, truncated to 32 bits.
- No combinational path from stall_if, redirect_valid or redirect_pc to any output; all outputs are registered except imem_addr, which is pc_q.
- Reset asserted mid-stall or mid-redirect: reset wins and produces the reset values above.

Test Plan:
1. Reset release, stall_if=0, imem preloaded with words 0x11111111, 0x22222222, 0x33333333 at 0x0/0x4/0x8.
   -> imem_addr sequence 0,4,8,C on consecutive cycles. One cycle after each address, id_instr shows the matching word with id_valid=1 and id_pc matching. fetch_cnt=3 after three fetch cycles.
2. Stall 2 cycles while pc_q=0x8.
   -> imem_addr stays 0x8; id_pc=0x4 and id_instr=0x22222222 hold for both cycles; fetch_cnt frozen. Fetch resumes with id_pc=0x8.
3. redirect_valid=1, redirect_pc=0x100, asserted together with stall_if=1.
   -> next cycle imem_addr=0x100, id_instr=0x00000013, id_valid=0, fetch_cnt unchanged. Following cycle id_pc=0x100, id_valid=1.
4. redirect_pc=0x102.
   -> fault=1, fault_pc=0x102, imem_addr frozen, id_valid=0 indefinitely. A later redirect to 0x200 is ignored. Asserting rst clears fault and restarts at RESET_PC.
5. Set pc_q to 0xFFFFFFFC via redirect, then free-run.
   -> id_pc=0xFFFFFFFC, id_pc4=0x00000000, next imem_addr=0x0.
6. Assert rst while a redirect to 0x40 is pending.
   -> after the edge, imem_addr=RESET_PC, id_valid=0, fetch_cnt=0, fault=0.
